// File: rtl/seven_segment_pkg.sv
// Shared types and segment patterns for the multiplexed seven-segment driver.
// Segment bits are {a,b,c,d,e,f,g} on [6:0], active-high.
package seven_segment_pkg;

    typedef logic [6:0] seg_t;

    localparam int MAX_DIGITS = 8;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational nibble to segment-pattern decoder.
// SEVSEG_HEX_EN defined: 10..15 show A,b,C,d,E,F; undefined: 10..15 are blank.
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
`ifdef SEVSEG_HEX_EN
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
`endif
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed multi-digit seven-segment driver with frame-aligned word commit
// and leading-zero suppression. Hex glyphs for 10..15 are enabled by SEVSEG_HEX_EN.
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    update,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic [3:0] nib [NUM_DIGITS];
    logic [3:0] cur_nib;
    seg_t       dec_seg;
    logic       upper_zero;
    logic       blank;
    logic       boundary;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign nib[gi] = disp_q[4*gi +: 4];
    end

    assign cur_nib = nib[idx_q];

    seven_segment_decode u_decode (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    // A digit is a leading zero only if it and every more-significant digit are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((IDX_W'(j) >= idx_q) && (nib[j] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign blank    = lz_en && (idx_q != '0) && upper_zero;
    assign boundary = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end

        // An update landing on the boundary itself bypasses the pending register.
        if (boundary) begin
            if (update) begin
                disp_d = digits;
            end else if (pend_vld_q) begin
                disp_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end else if (update) begin
            pend_d     = digits;
            pend_vld_d = 1'b1;
        end

        an_d    = NUM_DIGITS'(1) << idx_q;
        seg_d   = blank ? SEG_BLANK : dec_seg;
        frame_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            disp_q     <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '0;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            disp_q     <= disp_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Self-checking bench for seven_segment_mux with NUM_DIGITS=4, REFRESH_DIV=4.
// Expected per-digit patterns are queued when a word is driven and popped per dwell window.
module tb_seven_segment_mux;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h0;
    logic        update = 1'b0;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int errors = 0;
    int checks = 0;
    logic [6:0] exp_q [$];

    seven_segment_mux #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .digits (digits),
        .update (update),
        .lz_en  (lz_en),
        .seg    (seg),
        .an     (an),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
`ifdef SEVSEG_HEX_EN
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            4'hF: return 7'b1000111;
`endif
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic push_word(input logic [15:0] w, input logic lz);
        for (int d = 0; d < ND; d++) begin
            logic [3:0] n;
            logic       blank_d;
            n       = w[4*d +: 4];
            blank_d = lz && (d != 0) && ((w >> (4*d)) == 16'h0);
            exp_q.push_back(blank_d ? 7'b0000000 : ref_seg(n));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_update(input logic [15:0] w);
        digits = w;
        update = 1'b1;
        step(1);
        update = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (frame !== 1'b1 && n < 100);
        checks++;
        if (frame !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_timeout: got frame=%b want 1 within 100 cycles", name, frame);
        end
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if (seg !== 7'b0) begin errors++; $display("FAIL reset_seg: got %b want 0000000", seg); end
        checks++;
        if (an !== 4'b0) begin errors++; $display("FAIL reset_an: got %b want 0000", an); end
        checks++;
        if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", frame); end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            logic [3:0] exp_an;
            step(1);
            exp_an = 4'(1 << (((k - 1) / RD) % ND));
            checks++;
            if (an !== exp_an) begin errors++; $display("FAIL reset_an_step k=%0d: got %b want %b", k, an, exp_an); end
            checks++;
            if (frame !== ((k % 16) == 0)) begin errors++; $display("FAIL reset_frame_step k=%0d: got %b want %b", k, frame, (k % 16) == 0); end
            checks++;
            if (seg !== 7'b1111110) begin errors++; $display("FAIL reset_seg_step k=%0d: got %b want 1111110", k, seg); end
        end
        $display("reset: released, 32 cycles of stepping checked");
    endtask

    task automatic test_update_mid_frame();
        int n;
        step(5);
        push_word(16'h1234, 1'b0);
        drive_update(16'h1234);
        n = 0;
        while (n < 40) begin
            step(1);
            n++;
            if (frame === 1'b1) break;
            checks++;
            if (seg !== 7'b1111110) begin errors++; $display("FAIL mid_hold: got %b want 1111110", seg); end
        end
        checks++;
        if (frame !== 1'b1) begin errors++; $display("FAIL mid_frame_timeout: got frame=%b want 1", frame); end
        for (int d = 0; d < ND; d++) begin
            logic [6:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'bx;
            for (int c = 0; c < RD; c++) begin
                step(1);
                checks++;
                if (an !== 4'(1 << d)) begin errors++; $display("FAIL mid_an d=%0d: got %b want %b", d, an, 4'(1 << d)); end
                checks++;
                if (seg !== e) begin errors++; $display("FAIL mid_seg d=%0d: got %b want %b", d, seg, e); end
                checks++;
                if (frame !== (d == 3 && c == 3)) begin errors++; $display("FAIL mid_frame d=%0d c=%0d: got %b", d, c, frame); end
            end
        end
        $display("update_mid_frame: word 1234 committed at boundary");
    endtask

    task automatic test_back_to_back();
        drive_update(16'h1111);
        push_word(16'h2222, 1'b0);
        drive_update(16'h2222);
        wait_frame("double");
        for (int d = 0; d < ND; d++) begin
            logic [6:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'bx;
            for (int c = 0; c < RD; c++) begin
                step(1);
                checks++;
                if (seg !== e) begin errors++; $display("FAIL double_seg d=%0d: got %b want %b", d, seg, e); end
                checks++;
                if (an !== 4'(1 << d)) begin errors++; $display("FAIL double_an d=%0d: got %b want %b", d, an, 4'(1 << d)); end
            end
        end
        $display("back_to_back: 1111 then 2222, last wins");
        // Land the update exactly on the boundary cycle (16th edge after a frame pulse).
        step(RD * ND - 1);
        push_word(16'h5678, 1'b0);
        drive_update(16'h5678);
        checks++;
        if (frame !== 1'b1) begin errors++; $display("FAIL bypass_align: got frame=%b want 1", frame); end
        for (int d = 0; d < ND; d++) begin
            logic [6:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'bx;
            for (int c = 0; c < RD; c++) begin
                step(1);
                checks++;
                if (seg !== e) begin errors++; $display("FAIL bypass_seg d=%0d: got %b want %b", d, seg, e); end
                checks++;
                if (frame !== (d == 3 && c == 3)) begin errors++; $display("FAIL bypass_frame d=%0d c=%0d: got %b", d, c, frame); end
            end
        end
        $display("back_to_back: 5678 bypassed on boundary cycle");
    endtask

    task automatic test_leading_zeros();
        logic [15:0] words [2];
        words[0] = 16'h0050;
        words[1] = 16'h0000;
        lz_en = 1'b1;
        for (int w = 0; w < 2; w++) begin
            push_word(words[w], 1'b1);
            drive_update(words[w]);
            wait_frame("lz");
            for (int d = 0; d < ND; d++) begin
                logic [6:0] e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'bx;
                for (int c = 0; c < RD; c++) begin
                    step(1);
                    checks++;
                    if (seg !== e) begin errors++; $display("FAIL lz_seg word=%h d=%0d: got %b want %b", words[w], d, seg, e); end
                    checks++;
                    if (an !== 4'(1 << d)) begin errors++; $display("FAIL lz_an d=%0d: got %b want %b", d, an, 4'(1 << d)); end
                end
            end
            $display("leading_zeros: word %h checked", words[w]);
        end
        lz_en = 1'b0;
    endtask

    task automatic test_hex();
        push_word(16'hABCF, 1'b0);
        drive_update(16'hABCF);
        wait_frame("hex");
        for (int d = 0; d < ND; d++) begin
            logic [6:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'bx;
            for (int c = 0; c < RD; c++) begin
                step(1);
                checks++;
                if (seg !== e) begin errors++; $display("FAIL hex_seg d=%0d: got %b want %b", d, seg, e); end
            end
        end
        $display("hex: word ABCF checked");
    endtask

    task automatic test_reset_mid();
        drive_update(16'h9999);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (seg !== 7'b0) begin errors++; $display("FAIL rstmid_seg: got %b want 0000000", seg); end
        checks++;
        if (an !== 4'b0) begin errors++; $display("FAIL rstmid_an: got %b want 0000", an); end
        checks++;
        if (frame !== 1'b0) begin errors++; $display("FAIL rstmid_frame: got %b want 0", frame); end
        step(2);
        rst = 1'b0;
        for (int f = 0; f < 2; f++) begin
            push_word(16'h0000, 1'b0);
            for (int d = 0; d < ND; d++) begin
                logic [6:0] e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'bx;
                for (int c = 0; c < RD; c++) begin
                    step(1);
                    checks++;
                    if (seg !== e) begin errors++; $display("FAIL rstmid_seg f=%0d d=%0d: got %b want %b", f, d, seg, e); end
                    checks++;
                    if (an !== 4'(1 << d)) begin errors++; $display("FAIL rstmid_an f=%0d d=%0d: got %b want %b", f, d, an, 4'(1 << d)); end
                    checks++;
                    if (frame !== (d == 3 && c == 3)) begin errors++; $display("FAIL rstmid_frame f=%0d d=%0d c=%0d: got %b", f, d, c, frame); end
                end
            end
        end
        $display("reset_mid: pending 9999 discarded, display held at 0");
    endtask

    initial begin
        test_reset();
        test_update_mid_frame();
        test_back_to_back();
        test_leading_zeros();
        test_hex();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Time-multiplexed driver for a bank of `NUM_DIGITS` seven-segment digits sharing one segment bus. It is the multi-digit successor to the single-digit decoder.
- Latches a packed BCD/hex word on an `update` pulse.
- Commits the new word only at a frame boundary, so a displayed frame never mixes old and new digits.
- Cycles a one-hot digit enable at a programmable refresh rate, with optional leading-zero suppression.
- Sits between the value-producing logic and the board-level segment and anode pins.

## Interface
Parameters:
- `NUM_DIGITS`, 4, number of multiplexed digits; legal range 1..8.
- `REFRESH_DIV`, 1000, clock cycles each digit stays enabled; legal range ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `digits`  in  4*NUM_DIGITS  packed nibbles; digit i is `digits[4*i+3:4*i]`; digit 0 is the least significant (rightmost).
- `update`  in  1  single-cycle capture strobe for `digits`.
- `lz_en`  in  1  leading-zero suppression enable; level-sensitive, sampled every cycle.
- `seg`  out  7  segments a..g on bits [6:0], active-high; 0 is `7'b1111110`.
- `an`  out  NUM_DIGITS  one-hot digit enable, active-high.
- `frame`  out  1  one-cycle pulse at each frame boundary.

## Operation
**Registers**
- `cnt`: refresh counter, 0..REFRESH_DIV-1.
- `idx`: digit index, 0..NUM_DIGITS-1.
- `pend`, `pend_vld`: pending word and its valid flag.
- `disp`: committed display word.
- `seg`, `an`, `frame`: registered outputs.

**Refresh counter**
- `cnt` increments each cycle.
- At REFRESH_DIV-1 it returns to 0 and `idx` advances; `idx` wraps from NUM_DIGITS-1 to 0.
- Frame boundary = cycle where `cnt`=REFRESH_DIV-1 and `idx`=NUM_DIGITS-1.

**Capture**
- `update`=1 loads `pend`<=`digits` and sets `pend_vld`.
- A repeated `update` before commit overwrites `pend` (last wins).

**Commit, at the frame boundary**
- If `pend_vld`: `disp`<=`pend`, `pend_vld`<=0.
- If `update` is high in the boundary cycle itself: `disp`<=`digits` directly (bypass) and `pend_vld` stays 0.
- With no pending data, `disp` holds.

**Decode**
- Values 0..9 use the standard active-high patterns.
- 1=`0110000`, 8=`1111111`.
- Values 10..15 depend on the Configuration macro below.

**Leading-zero blank**
- Digit i≠0 is blanked (seg=0) when `lz_en`=1 and every `disp` nibble i..NUM_DIGITS-1 equals 0.
- Digit 0 is never suppressed.

**Output registers**
- Each cycle: `an`<=onehot(`idx`), `seg`<=decode/blank of `disp` nibble `idx`.
- `frame`<=1 in the cycle after a frame boundary.

**NUM_DIGITS=1**
- `idx` is constant 0.
- Every `cnt` wrap is a frame boundary.

## Timing
- **Reset**: while `rst`=1, `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pend_vld`=0, `seg`=0, `an`=0, `frame`=0.
- **First edge after reset release**: `an`=1 (digit 0) and `seg`=`1111110`.
- **Output latency**: one cycle from `idx`/`disp` to `seg`/`an`. `seg` and `an` change on the same edge; there are no glitches between them.
- **Dwell time**: each digit is enabled for exactly REFRESH_DIV cycles. A frame is NUM_DIGITS*REFRESH_DIV cycles.
- **Update to display**: a new word appears on `seg` one cycle after the first frame boundary following the `update` (worst case one frame plus one cycle).
- **REFRESH_DIV=1**: `idx` advances every cycle and frame boundaries occur every NUM_DIGITS cycles.
- **Reset mid-frame**: asserting `rst` discards `pend` and `pend_vld` immediately and blanks the outputs asynchronously.

## Configuration
- `SEVSEG_HEX_EN` defined: values 10..15 decode to the following patterns.
  - A=`1110111`
  - b=`0011111`
  - C=`1001110`
  - d=`0111101`
  - E=`1001111`
  - F=`1000111`
- `SEVSEG_HEX_EN` undefined: values 10..15 drive seg=`0000000` (blank).
- In both builds, leading-zero suppression treats only value 0 as zero.

## Structure
- Package `seven_segment_pkg`:
  - `seg_t` (logic [6:0]).
  - Constants `SEG_0`..`SEG_9`, `SEG_A`..`SEG_F`, `SEG_BLANK`.
  - `MAX_DIGITS`=8.
- Sub-module `seven_segment_decode`: combinational nibble→`seg_t`, holding the `SEVSEG_HEX_EN` switch. Instantiated once on the `idx`-selected nibble.
- Top level holds the counters, capture/commit logic, blanking and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4.
- **Reset release**: outputs are 0 during `rst`. First edge after release gives `an`=`0001`, `seg`=`1111110`. `an` steps `0010`,`0100`,`1000` every 4 cycles, and `frame` pulses every 16 cycles.
- **Update mid-frame**: `update` with `digits`=`16'h1234` while `idx`=1. `disp` stays 0 until the boundary. The next frame shows `an`=`0001` with 4 (`0110011`) and `an`=`1000` with 1 (`0110000`).
- **Double update and bypass**:
  - `update` 16'h1111 then 16'h2222 before the boundary → the next frame shows only 2s.
  - `update` exactly in the boundary cycle → that value is committed immediately.
- **Leading zeros**: `digits`=`16'h0050` with `lz_en`=1 → digits 3,2 give seg=0, digit 1 shows 5, digit 0 shows 0. With `digits`=0, digit 0 still shows `1111110`.
- **Hex build**: `digits`=`16'hABCF` gives F,C,b,A with `SEVSEG_HEX_EN`; without the macro all four digits are blank.
- **Reset mid-operation**: `rst` asserted with `pend_vld`=1 → after release the display shows 0 and the pending value is never displayed.
